// File: rtl/rv_div_seq.sv
// rv_div_seq: sequential RV32M divider for DIV/DIVU/REM/REMU.
// Radix-2 restoring division retires one quotient bit per clock on operand magnitudes.
// Signs are applied when the result is registered.
// Divide-by-zero and signed overflow produce fixed results.
// With EARLY_OUT set, those cases take a single CALC step instead of WIDTH steps.
// The ce_i/ce_o strobe handshake matches the execute-stage multiplier.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | waiting for ce_i; busy_o low; ce_o strobes here after DONE
// S_CALC | one restoring iteration per edge, count runs WIDTH-1 down to 0
// S_DONE | final sign fix-up; result_o and ce_o load on the exit edge
module rv_div_seq #(
    parameter int WIDTH     = 32,
    parameter bit EARLY_OUT = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             ce_i,
    input  logic             kill_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] op1_i,
    input  logic [WIDTH-1:0] op2_i,
    output logic             busy_o,
    output logic             ce_o,
    output logic [WIDTH-1:0] result_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] MIN_INT  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [CW-1:0]    count;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] special_res;
    logic             op_rem;
    logic             neg_q;
    logic             neg_r;
    logic             special;

    logic             is_signed;
    logic             sign1;
    logic             sign2;
    logic             div_zero;
    logic             sgn_ovf;
    logic             start;
    logic [WIDTH-1:0] abs1;
    logic [WIDTH-1:0] abs2;
    logic [WIDTH-1:0] spec_val;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    logic             finish;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;
    logic [WIDTH-1:0] final_res;

    // Operand decode: magnitudes, sign flags and the fixed special-case result.
    // The magnitude of MIN_INT wraps back to MIN_INT, which is 2^(WIDTH-1) read unsigned.
    always_comb begin
        is_signed = ~op_i[0];
        sign1     = is_signed & op1_i[WIDTH-1];
        sign2     = is_signed & op2_i[WIDTH-1];
        abs1      = sign1 ? ('0 - op1_i) : op1_i;
        abs2      = sign2 ? ('0 - op2_i) : op2_i;
        div_zero  = (op2_i == '0);
        sgn_ovf   = is_signed && (op1_i == MIN_INT) && (op2_i == ALL_ONES);
        if (op_i[1]) begin
            spec_val = div_zero ? op1_i : '0;
        end else begin
            spec_val = div_zero ? ALL_ONES : MIN_INT;
        end
        start     = (state == S_IDLE) && ce_i && !kill_i;
    end

    // One restoring step: shift in the next dividend bit, then trial-subtract the divisor.
    always_comb begin
        shifted = {rem, quo[WIDTH-1]};
        diff    = shifted - {1'b0, divisor};
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; kill_i overrides everything and returns to idle.
    always_comb begin
        state_nxt = state;
        if (kill_i) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (ce_i) state_nxt = S_CALC;
                S_CALC:  if (count == '0) state_nxt = S_DONE;
                S_DONE:  state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // State outputs and the sign-corrected result.
    // Special cases bypass the sign fix-up entirely.
    always_comb begin
        busy_o = (state != S_IDLE);
        finish = (state == S_DONE) && !kill_i;
        q_fix  = neg_q ? ('0 - quo) : quo;
        r_fix  = neg_r ? ('0 - rem) : rem;
        if (special) begin
            final_res = special_res;
        end else begin
            final_res = op_rem ? r_fix : q_fix;
        end
    end

    // Datapath: capture on start, iterate in CALC, register the result on the DONE exit.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count       <= '0;
            rem         <= '0;
            quo         <= '0;
            divisor     <= '0;
            special_res <= '0;
            op_rem      <= 1'b0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            special     <= 1'b0;
            ce_o        <= 1'b0;
            result_o    <= '0;
        end else begin
            ce_o <= finish;
            if (finish) begin
                result_o <= final_res;
            end
            if (start) begin
                op_rem      <= op_i[1];
                neg_q       <= sign1 ^ sign2;
                neg_r       <= sign1;
                special     <= div_zero | sgn_ovf;
                special_res <= spec_val;
                divisor     <= abs2;
                quo         <= abs1;
                rem         <= '0;
                // Special operands get one CALC step so the early-out latency stays fixed.
                count       <= (EARLY_OUT && (div_zero || sgn_ovf)) ? '0 : CW'(WIDTH - 1);
            end else if (state == S_CALC) begin
                count <= count - CW'(1);
                if (!diff[WIDTH]) begin
                    rem <= diff[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], 1'b1};
                end else begin
                    rem <= shifted[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], 1'b0};
                end
            end
        end
    end

endmodule

// File: tb/tb_rv_div_seq.sv
// tb_rv_div_seq: directed and randomised checks of rv_div_seq.
// Two instances share the same stimulus: one with early-out and one without.
module tb_rv_div_seq;

    localparam logic [31:0] MIN_INT  = 32'h8000_0000;
    localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        ce_i = 1'b0;
    logic        kill_i = 1'b0;
    logic [1:0]  op_i = 2'b00;
    logic [31:0] op1_i = '0;
    logic [31:0] op2_i = '0;

    logic        busy_a, ce_a;
    logic [31:0] res_a;
    logic        busy_b, ce_b;
    logic [31:0] res_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_i = ~clk_i;

    rv_div_seq #(.WIDTH(32), .EARLY_OUT(1'b1)) dut_a (
        .clk_i(clk_i), .rst_ni(rst_ni), .ce_i(ce_i), .kill_i(kill_i),
        .op_i(op_i), .op1_i(op1_i), .op2_i(op2_i),
        .busy_o(busy_a), .ce_o(ce_a), .result_o(res_a)
    );

    rv_div_seq #(.WIDTH(32), .EARLY_OUT(1'b0)) dut_b (
        .clk_i(clk_i), .rst_ni(rst_ni), .ce_i(ce_i), .kill_i(kill_i),
        .op_i(op_i), .op1_i(op1_i), .op2_i(op2_i),
        .busy_o(busy_b), .ce_o(ce_b), .result_o(res_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return op[1] ? a : ALL_ONES;
        if (!op[0] && a == MIN_INT && b == ALL_ONES) return op[1] ? 32'd0 : MIN_INT;
        case (op)
            2'b00:   return $signed(a) / $signed(b);
            2'b01:   return a / b;
            2'b10:   return $signed(a) % $signed(b);
            default: return a % b;
        endcase
    endfunction

    // Issue one operation and watch both units for 36 cycles after the accepting edge.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input string tag);
        int lat_a, lat_b, n_a, n_b, exp_lat_a;
        logic [31:0] r_a, r_b;
        logic spec;
        spec = (b == 32'd0) || (!op[0] && a == MIN_INT && b == ALL_ONES);
        exp_lat_a = spec ? 2 : 33;
        lat_a = 0; lat_b = 0; n_a = 0; n_b = 0; r_a = '0; r_b = '0;
        @(negedge clk_i);
        ce_i = 1'b1; op_i = op; op1_i = a; op2_i = b;
        @(posedge clk_i); #1;
        ce_i = 1'b0;
        check({tag, " busy"}, {31'd0, busy_a}, 32'd1);
        for (int k = 1; k <= 36; k++) begin
            @(posedge clk_i); #1;
            if (ce_a) begin
                n_a++;
                if (lat_a == 0) begin lat_a = k; r_a = res_a; end
            end
            if (ce_b) begin
                n_b++;
                if (lat_b == 0) begin lat_b = k; r_b = res_b; end
            end
        end
        check({tag, " result eo"}, r_a, exp);
        check({tag, " result full"}, r_b, exp);
        check({tag, " latency eo"}, 32'(lat_a), 32'(exp_lat_a));
        check({tag, " latency full"}, 32'(lat_b), 32'd33);
        check({tag, " strobes eo"}, 32'(n_a), 32'd1);
        check({tag, " strobes full"}, 32'(n_b), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        logic [1:0]  r_op;
        logic [31:0] r_a, r_b;

        #2;
        check("reset busy", {31'd0, busy_a}, 32'd0);
        check("reset ce", {31'd0, ce_a}, 32'd0);
        check("reset result", res_a, 32'd0);
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;

        run_op(2'b01, 32'd100, 32'd7, 32'd14, "divu 100/7");
        run_op(2'b11, 32'd100, 32'd7, 32'd2, "remu 100/7");
        run_op(2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, "div -7/2");
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, "rem -7/2");
        run_op(2'b00, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, "div 7/-2");
        run_op(2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, "rem 7/-2");
        run_op(2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF, "divu 5/0");
        run_op(2'b11, 32'd5, 32'd0, 32'd5, "remu 5/0");
        run_op(2'b00, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, "div -5/0");
        run_op(2'b10, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, "rem -5/0");
        run_op(2'b00, MIN_INT, ALL_ONES, MIN_INT, "div ovf");
        run_op(2'b10, MIN_INT, ALL_ONES, 32'd0, "rem ovf");
        run_op(2'b01, MIN_INT, ALL_ONES, 32'd0, "divu min/ones");
        run_op(2'b11, MIN_INT, ALL_ONES, MIN_INT, "remu min/ones");
        run_op(2'b00, MIN_INT, 32'd2, 32'hC000_0000, "div min/2");
        run_op(2'b01, ALL_ONES, 32'd1, ALL_ONES, "divu ones/1");

        // ce_i held high: one accept per ce_o cycle, period WIDTH+2.
        @(negedge clk_i);
        ce_i = 1'b1; op_i = 2'b01; op1_i = 32'd100; op2_i = 32'd7;
        @(posedge clk_i); #1;
        pulses = 0;
        for (int k = 1; k <= 101; k++) begin
            @(posedge clk_i); #1;
            if (ce_a) begin
                pulses++;
                check("b2b busy in ce cycle", {31'd0, busy_a}, 32'd0);
                check("b2b result", res_a, 32'd14);
            end
        end
        ce_i = 1'b0;
        check("b2b strobe count", 32'(pulses), 32'd3);
        repeat (40) @(posedge clk_i);
        #1;
        check("b2b idle after", {31'd0, busy_a}, 32'd0);

        // ce_i while busy is ignored.
        @(negedge clk_i);
        ce_i = 1'b1; op_i = 2'b01; op1_i = 32'd100; op2_i = 32'd7;
        @(posedge clk_i); #1;
        ce_i = 1'b0;
        pulses = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk_i); #1;
            if (k == 5) begin ce_i = 1'b1; op_i = 2'b11; op1_i = 32'd9; op2_i = 32'd4; end
            if (k == 6) ce_i = 1'b0;
            if (ce_a) begin
                pulses++;
                check("ignored ce latency", 32'(k), 32'd33);
                check("ignored ce result", res_a, 32'd14);
            end
        end
        check("ignored ce strobes", 32'(pulses), 32'd1);

        // kill mid-operation: no strobe, result untouched.
        @(negedge clk_i);
        ce_i = 1'b1; op_i = 2'b01; op1_i = 32'h0000_1000; op2_i = 32'd3;
        @(posedge clk_i); #1;
        ce_i = 1'b0;
        pulses = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk_i); #1;
            if (k == 10) kill_i = 1'b1;
            if (k == 11) begin
                kill_i = 1'b0;
                check("kill busy eo", {31'd0, busy_a}, 32'd0);
                check("kill busy full", {31'd0, busy_b}, 32'd0);
            end
            if (ce_a || ce_b) pulses++;
        end
        check("kill strobes", 32'(pulses), 32'd0);
        check("kill result held", res_a, 32'd14);

        // kill together with ce in idle drops the start.
        @(negedge clk_i);
        ce_i = 1'b1; kill_i = 1'b1; op_i = 2'b01; op1_i = 32'd50; op2_i = 32'd5;
        @(posedge clk_i); #1;
        ce_i = 1'b0; kill_i = 1'b0;
        check("kill+ce busy", {31'd0, busy_a}, 32'd0);

        run_op(2'b01, 32'h0000_1000, 32'd3, 32'h0000_0555, "divu after kill");

        // asynchronous reset mid-operation.
        @(negedge clk_i);
        ce_i = 1'b1; op_i = 2'b01; op1_i = 32'd100; op2_i = 32'd7;
        @(posedge clk_i); #1;
        ce_i = 1'b0;
        repeat (5) @(posedge clk_i);
        #1;
        rst_ni = 1'b0;
        #1;
        check("mid reset busy", {31'd0, busy_a}, 32'd0);
        check("mid reset ce", {31'd0, ce_a}, 32'd0);
        check("mid reset result", res_a, 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        pulses = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk_i); #1;
            if (ce_a || ce_b) pulses++;
        end
        check("post reset strobes", 32'(pulses), 32'd0);

        // randomised operations against the reference model.
        for (int i = 0; i < 150; i++) begin
            r_op = 2'($urandom_range(0, 3));
            r_a  = $urandom;
            if (i % 10 == 0) r_a = MIN_INT;
            case ($urandom_range(0, 3))
                0:       r_b = 32'($urandom_range(0, 2));
                1:       r_b = $urandom;
                2:       r_b = 32'($urandom_range(1, 255));
                default: r_b = 32'd0 - 32'($urandom_range(1, 255));
            endcase
            if (i % 25 == 3) r_b = ALL_ONES;
            run_op(r_op, r_a, r_b, ref_div(r_op, r_a, r_b), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
